pwm_fade_sequencer: RTL



---
 rtl/pwm_fade_sequencer_pkg.sv | 34 +++
 rtl/pwm_fade_sequencer_if.sv | 24 ++
 rtl/fade_tick_timer.sv | 28 ++
 rtl/pwm_fade_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared constants and types for the PWM fade sequencer:
// register map, CTRL/STATUS bit positions, FSM state encoding and reset values.
package pwm_fade_sequencer_pkg;

    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_STATUS   = 4'd1;
    localparam logic [3:0] REG_MIN      = 4'd2;
    localparam logic [3:0] REG_MAX      = 4'd3;
    localparam logic [3:0] REG_STEP     = 4'd4;
    localparam logic [3:0] REG_INTERVAL = 4'd5;
    localparam logic [3:0] REG_CUR      = 4'd6;

    localparam int CTRL_START = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_ABORT = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam int INTERVAL_W = 24;

    localparam int                    MIN_DUTY_RST = 0;
    localparam int                    MAX_DUTY_RST = 1000;
    localparam int                    STEP_RST     = 1;
    localparam logic [INTERVAL_W-1:0] INTERVAL_RST = 24'd100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT
    } fade_state_e;

endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// Avalon-MM bus bundle; one instance serves as the CPU-facing slave port,
// another as the master port towards the PWM compare register.
interface pwm_fade_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              chipselect;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output chipselect, read, write, address, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/fade_tick_timer.sv
// Down-counter that times the pause between PWM updates: load arms it for
// max(interval,1) cycles, expire is high during the last of them.
module fade_tick_timer
    import pwm_fade_sequencer_pkg::*;
(
    input  logic                  csi_clk,
    input  logic                  csi_reset_n,
    input  logic                  load,
    input  logic [INTERVAL_W-1:0] interval,
    output logic                  expire
);

    logic [INTERVAL_W-1:0] count;

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            count <= '0;
        end else if (load) begin
            // An interval of 0 behaves like 1: expire already in the first cycle.
            count <= (interval == '0) ? '0 : interval - 1'b1;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Triangle-wave fader: ramps a duty value MIN->MAX->MIN and pushes every step
// to a PWM compare register over an Avalon-MM master, configured via a slave.
module pwm_fade_sequencer
    import pwm_fade_sequencer_pkg::*;
#(
    parameter logic [3:0] PWM_ADDR = 4'd0,
    parameter int         DUTY_W   = 10
) (
    input  logic                 csi_clk,
    input  logic                 csi_reset_n,
    pwm_fade_sequencer_if.slave  avs,
    pwm_fade_sequencer_if.master avm,
    output logic                 coe_busy
);

    typedef logic [DUTY_W-1:0] duty_t;

    duty_t                 min_duty, max_duty, step, cur, cur_next;
    logic [INTERVAL_W-1:0] interval;
    fade_state_e           state, state_next;
    logic                  dir, dir_next, done, done_next, err, err_next;
    logic                  loop, loop_next, abort_pend, abort_pend_next;
    logic                  wr_en, rd_en, ctrl_wr, start_req, abort_req;
    logic                  busy, handshake, expire, going_down;
    duty_t                 step_eff, up_next, down_next;
    logic [DUTY_W:0]       up_sum, down_floor;
    logic [31:0]           rd_mux;
    logic                  unused_inputs;

    assign wr_en     = avs.chipselect && avs.write;
    assign rd_en     = avs.chipselect && avs.read;
    assign ctrl_wr   = wr_en && (avs.address == REG_CTRL);
    assign abort_req = ctrl_wr && avs.writedata[CTRL_ABORT];
    assign start_req = ctrl_wr && avs.writedata[CTRL_START] && !avs.writedata[CTRL_ABORT];
    assign busy      = (state != ST_IDLE);
    assign handshake = (state == ST_WRITE) && !avm.waitrequest;

    // Sums are one bit wider so cur+step and MIN+step cannot wrap.
    assign step_eff   = (step == '0) ? duty_t'(1) : step;
    assign up_sum     = {1'b0, cur} + {1'b0, step_eff};
    assign up_next    = (up_sum >= {1'b0, max_duty}) ? max_duty : up_sum[DUTY_W-1:0];
    assign down_floor = {1'b0, min_duty} + {1'b0, step_eff};
    assign down_next  = ({1'b0, cur} < down_floor) ? min_duty : cur - step_eff;
    assign going_down = dir || (cur == max_duty);

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            min_duty <= DUTY_W'(MIN_DUTY_RST);
            max_duty <= DUTY_W'(MAX_DUTY_RST);
            step     <= DUTY_W'(STEP_RST);
            interval <= INTERVAL_RST;
        end else if (wr_en && !busy) begin
            case (avs.address)
                REG_MIN:      min_duty <= avs.writedata[DUTY_W-1:0];
                REG_MAX:      max_duty <= avs.writedata[DUTY_W-1:0];
                REG_STEP:     step     <= avs.writedata[DUTY_W-1:0];
                REG_INTERVAL: interval <= avs.writedata[INTERVAL_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            REG_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done;
                rd_mux[STAT_ERR]  = err;
            end
            REG_MIN:      rd_mux = 32'(min_duty);
            REG_MAX:      rd_mux = 32'(max_duty);
            REG_STEP:     rd_mux = 32'(step);
            REG_INTERVAL: rd_mux = 32'(interval);
            REG_CUR:      rd_mux = 32'(cur);
            default: ;
        endcase
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) avs.readdata <= '0;
        else if (rd_en)   avs.readdata <= rd_mux;
    end

    // NOTE: state and datapath registers take only non-blocking assignments so
    // every flop samples the pre-edge values computed by the combinational block.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state      <= ST_IDLE;
            cur        <= '0;
            dir        <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            loop       <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_next;
            cur        <= cur_next;
            dir        <= dir_next;
            done       <= done_next;
            err        <= err_next;
            loop       <= loop_next;
            abort_pend <= abort_pend_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no branch can
        // leave one unassigned and infer a latch.
        state_next      = state;
        cur_next        = cur;
        dir_next        = dir;
        done_next       = done;
        err_next        = err;
        loop_next       = loop;
        abort_pend_next = abort_pend;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    if (min_duty > max_duty) begin
                        err_next = 1'b1;
                    end else begin
                        cur_next        = min_duty;
                        dir_next        = 1'b0;
                        done_next       = 1'b0;
                        err_next        = 1'b0;
                        loop_next       = avs.writedata[CTRL_LOOP];
                        abort_pend_next = 1'b0;
                        state_next      = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // An abort never cuts a transfer short; it takes effect on acceptance.
                if (handshake) begin
                    if (abort_req || abort_pend) begin
                        state_next      = ST_IDLE;
                        done_next       = 1'b0;
                        abort_pend_next = 1'b0;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (abort_req) begin
                    abort_pend_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (abort_req) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b0;
                end else if (expire) begin
                    if (going_down && cur == min_duty && !loop) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else if (going_down && cur != min_duty) begin
                        cur_next   = down_next;
                        dir_next   = 1'b1;
                        state_next = ST_WRITE;
                    end else begin
                        cur_next   = up_next;
                        dir_next   = (up_next == max_duty);
                        state_next = ST_WRITE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    fade_tick_timer u_timer (
        .csi_clk     (csi_clk),
        .csi_reset_n (csi_reset_n),
        .load        (handshake),
        .interval    (interval),
        .expire      (expire)
    );

    // Master strobes decode straight from state, so reset drops them at once.
    assign avm.address    = PWM_ADDR;
    assign avm.write      = (state == ST_WRITE);
    assign avm.chipselect = (state == ST_WRITE);
    assign avm.read       = 1'b0;
    assign avm.writedata  = 32'(cur);
    assign avs.waitrequest = 1'b0;
    assign coe_busy       = busy;

    assign unused_inputs = ^{avs.writedata[31:INTERVAL_W], avm.readdata};

endmodule
